mc_maindec: RTL and testbench

//  Main control FSM for the multicycle MIPS datapath; next generation of the single-cycle main decoder.

---
 rtl/mc_maindec_if.sv | 34 +++
 rtl/mc_maindec.sv | 171 +++++++++++++++++
 tb/tb_mc_maindec.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mc_maindec_if.sv
// Control bundle between the multicycle main decoder and its datapath/controller neighbours.
// master drives the opcode and memory handshake; slave is the decoder itself.
interface mc_maindec_if;
    logic [5:0] op;
    logic       mem_ready;
    logic [3:0] state;
    logic       iord;
    logic       alusrca;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       branchne;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       memwrite;
    logic       zeroext;
    logic       illegal_op;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;

    modport master (
        output op, mem_ready,
        input  state, iord, alusrca, irwrite, pcwrite, branch, branchne, regwrite,
               regdst, memtoreg, memwrite, zeroext, illegal_op, alusrcb, pcsrc, aluop
    );

    modport slave (
        input  op, mem_ready,
        output state, iord, alusrca, irwrite, pcwrite, branch, branchne, regwrite,
               regdst, memtoreg, memwrite, zeroext, illegal_op, alusrcb, pcsrc, aluop
    );
endinterface

// File: rtl/mc_maindec.sv
// Main control FSM for the multicycle MIPS datapath: sequences FETCH/DECODE/EXEC/MEM/WB
// with memory wait states, optional BNE/ORI and an illegal-opcode flag.
module mc_maindec #(
    parameter bit EN_BNE = 1'b1,
    parameter bit EN_ORI = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    mc_maindec_if.slave bus
);
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_RTYPEEX = 4'd6;
    localparam logic [3:0] S_RTYPEWB = 4'd7;
    localparam logic [3:0] S_BEQEX   = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JEX     = 4'd11;
    localparam logic [3:0] S_BNEEX   = 4'd12;
    localparam logic [3:0] S_ORIEX   = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       op_legal;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        op_legal = 1'b0;
        case (bus.op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
            OP_BNE:                                        op_legal = EN_BNE;
            OP_ORI:                                        op_legal = EN_ORI;
            default:                                       op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_RTYPE:      state_d = S_RTYPEEX;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BEQEX;
                    OP_ADDI:       state_d = S_ADDIEX;
                    OP_J:          state_d = S_JEX;
                    // Disabled options fall back to FETCH so their EX state is never reached.
                    OP_BNE:        state_d = EN_BNE ? S_BNEEX : S_FETCH;
                    OP_ORI:        state_d = EN_ORI ? S_ORIEX : S_FETCH;
                    default:       state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (bus.op == OP_LW)      state_d = S_MEMRD;
                else if (bus.op == OP_SW) state_d = S_MEMWR;
                else                      state_d = S_FETCH;
            end
            S_MEMRD:   state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ORIEX:   state_d = EN_ORI ? S_ADDIWB : S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        bus.state      = state_q;
        bus.iord       = 1'b0;
        bus.alusrca    = 1'b0;
        bus.irwrite    = 1'b0;
        bus.pcwrite    = 1'b0;
        bus.branch     = 1'b0;
        bus.branchne   = 1'b0;
        bus.regwrite   = 1'b0;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.memwrite   = 1'b0;
        bus.zeroext    = 1'b0;
        bus.illegal_op = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.pcsrc      = 2'b00;
        bus.aluop      = 2'b00;
        case (state_q)
            S_FETCH: begin
                // PC+4 and IR load only once the instruction word has arrived.
                bus.alusrcb = 2'b01;
                bus.irwrite = bus.mem_ready;
                bus.pcwrite = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alusrcb    = 2'b11;
                bus.illegal_op = ~op_legal;
            end
            S_MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            S_MEMRD: bus.iord = 1'b1;
            S_MEMWB: begin
                bus.regwrite = 1'b1;
                bus.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b10;
            end
            S_RTYPEWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
            end
            S_BEQEX: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b01;
                bus.pcsrc   = 2'b01;
                bus.branch  = 1'b1;
            end
            S_ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            S_ADDIWB: bus.regwrite = 1'b1;
            S_JEX: begin
                bus.pcsrc   = 2'b10;
                bus.pcwrite = 1'b1;
            end
            S_BNEEX: begin
                if (EN_BNE) begin
                    bus.alusrca  = 1'b1;
                    bus.aluop    = 2'b01;
                    bus.pcsrc    = 2'b01;
                    bus.branchne = 1'b1;
                end
            end
            S_ORIEX: begin
                if (EN_ORI) begin
                    bus.alusrca = 1'b1;
                    bus.alusrcb = 2'b10;
                    bus.zeroext = 1'b1;
                    bus.aluop   = 2'b11;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mc_maindec.sv
// Randomised scoreboard bench for mc_maindec: one instance with both options enabled,
// one with both disabled; expected per-cycle outputs come from instruction-level step plans.
module tb_mc_maindec;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_maindec_if ifa ();
    mc_maindec_if ifb ();

    mc_maindec #(.EN_BNE(1'b1), .EN_ORI(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    mc_maindec #(.EN_BNE(1'b0), .EN_ORI(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

    typedef struct {
        int st;
        bit mr;
    } step_t;

    step_t       plan[$];
    logic [21:0] exp_a[$];
    logic [21:0] exp_b[$];
    int          errors = 0;
    int          checks = 0;

    function automatic bit legal(logic [5:0] op, bit bne, bit ori);
        case (op)
            6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02: return 1'b1;
            6'h05:   return bne;
            6'h0d:   return ori;
            default: return 1'b0;
        endcase
    endfunction

    // {state, alusrcb, pcsrc, aluop, iord, alusrca, irwrite, pcwrite, branch, branchne,
    //  regwrite, regdst, memtoreg, memwrite, zeroext, illegal_op}
    function automatic logic [21:0] expect_vec(int st, bit mr, bit ill);
        logic [1:0] srcb = 2'b00, pcs = 2'b00, aop = 2'b00;
        bit iord = 0, srca = 0, irw = 0, pcw = 0, br = 0, brne = 0;
        bit rw = 0, rd = 0, m2r = 0, mw = 0, zx = 0;
        case (st)
            0:  begin srcb = 2'b01; irw = mr; pcw = mr; end
            1:  srcb = 2'b11;
            2:  begin srca = 1; srcb = 2'b10; end
            3:  iord = 1;
            4:  begin rw = 1; m2r = 1; end
            5:  begin iord = 1; mw = 1; end
            6:  begin srca = 1; aop = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            8:  begin srca = 1; aop = 2'b01; pcs = 2'b01; br = 1; end
            9:  begin srca = 1; srcb = 2'b10; end
            10: rw = 1;
            11: begin pcs = 2'b10; pcw = 1; end
            12: begin srca = 1; aop = 2'b01; pcs = 2'b01; brne = 1; end
            13: begin srca = 1; srcb = 2'b10; zx = 1; aop = 2'b11; end
            default: ;
        endcase
        return {st[3:0], srcb, pcs, aop, iord, srca, irw, pcw, br, brne, rw, rd, m2r, mw, zx, ill};
    endfunction

    function automatic logic [21:0] actual_a();
        return {ifa.state, ifa.alusrcb, ifa.pcsrc, ifa.aluop, ifa.iord, ifa.alusrca, ifa.irwrite,
                ifa.pcwrite, ifa.branch, ifa.branchne, ifa.regwrite, ifa.regdst, ifa.memtoreg,
                ifa.memwrite, ifa.zeroext, ifa.illegal_op};
    endfunction

    function automatic logic [21:0] actual_b();
        return {ifb.state, ifb.alusrcb, ifb.pcsrc, ifb.aluop, ifb.iord, ifb.alusrca, ifb.irwrite,
                ifb.pcwrite, ifb.branch, ifb.branchne, ifb.regwrite, ifb.regdst, ifb.memtoreg,
                ifb.memwrite, ifb.zeroext, ifb.illegal_op};
    endfunction

    // Instruction-level walk: fetch waits, decode, then the op's execution path.
    task automatic build(input logic [5:0] op, input bit bne, input bit ori, input int fw, input int mw);
        plan.delete();
        for (int i = 0; i < fw; i++) plan.push_back('{0, 1'b0});
        plan.push_back('{0, 1'b1});
        plan.push_back('{1, 1'($urandom)});
        case (op)
            6'h00: begin plan.push_back('{6, 1'($urandom)}); plan.push_back('{7, 1'($urandom)}); end
            6'h23: begin
                plan.push_back('{2, 1'($urandom)});
                for (int i = 0; i < mw; i++) plan.push_back('{3, 1'b0});
                plan.push_back('{3, 1'b1});
                plan.push_back('{4, 1'($urandom)});
            end
            6'h2b: begin
                plan.push_back('{2, 1'($urandom)});
                for (int i = 0; i < mw; i++) plan.push_back('{5, 1'b0});
                plan.push_back('{5, 1'b1});
            end
            6'h04: plan.push_back('{8, 1'($urandom)});
            6'h08: begin plan.push_back('{9, 1'($urandom)}); plan.push_back('{10, 1'($urandom)}); end
            6'h02: plan.push_back('{11, 1'($urandom)});
            6'h05: if (bne) plan.push_back('{12, 1'($urandom)});
            6'h0d: if (ori) begin plan.push_back('{13, 1'($urandom)}); plan.push_back('{10, 1'($urandom)}); end
            default: ;
        endcase
    endtask

    // Runs one instruction on the selected instance while the other idles in FETCH.
    // rst_at >= 0 asserts reset during that step and abandons the rest of the plan.
    task automatic run_instr(input bit which, input logic [5:0] op, input int fw, input int mw, input int rst_at);
        bit bne = (which == 1'b0);
        bit ori = (which == 1'b0);
        int n;
        build(op, bne, ori, fw, mw);
        n = plan.size();
        if (rst_at >= 0 && rst_at < n) n = rst_at + 1;
        for (int i = 0; i < n; i++) begin
            logic [21:0] e;
            e = expect_vec(plan[i].st, plan[i].mr, (plan[i].st == 1) && !legal(op, bne, ori));
            reset = (i == rst_at);
            if (which == 1'b0) begin
                ifa.op = op; ifa.mem_ready = plan[i].mr; ifb.mem_ready = 1'b0;
                exp_a.push_back(e);
                exp_b.push_back(expect_vec(0, 1'b0, 1'b0));
            end else begin
                ifb.op = op; ifb.mem_ready = plan[i].mr; ifa.mem_ready = 1'b0;
                exp_b.push_back(e);
                exp_a.push_back(expect_vec(0, 1'b0, 1'b0));
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got state=%0d vec=%h, want state=%0d vec=%h",
                     name, act[21:18], act, exp[21:18], exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_a.size() > 0) check("dut_a(bne,ori)", actual_a(), exp_a.pop_front());
        if (exp_b.size() > 0) check("dut_b(plain)", actual_b(), exp_b.pop_front());
    end

    logic [5:0] op_pool[10];

    initial begin
        op_pool = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02, 6'h05, 6'h0d, 6'h3f, 6'h00};
        reset = 1'b1;
        ifa.op = 6'h00; ifa.mem_ready = 1'b0;
        ifb.op = 6'h00; ifb.mem_ready = 1'b0;
        @(posedge clk); #1;
        // Held in reset with mem_ready=1: FETCH values with irwrite/pcwrite following mem_ready.
        ifa.mem_ready = 1'b1; ifb.mem_ready = 1'b1;
        exp_a.push_back(expect_vec(0, 1'b1, 1'b0));
        exp_b.push_back(expect_vec(0, 1'b1, 1'b0));
        @(posedge clk); #1;
        reset = 1'b0;

        run_instr(1'b0, 6'h23, 0, 0, -1);   // lw, no waits
        run_instr(1'b0, 6'h2b, 0, 3, -1);   // sw, 3 wait cycles in MEMWR
        run_instr(1'b0, 6'h00, 2, 0, -1);   // R-type after 2 fetch waits
        run_instr(1'b0, 6'h05, 0, 0, -1);   // bne enabled
        run_instr(1'b1, 6'h05, 0, 0, -1);   // bne disabled -> illegal
        run_instr(1'b0, 6'h0d, 0, 0, -1);   // ori enabled
        run_instr(1'b1, 6'h0d, 0, 0, -1);   // ori disabled -> illegal
        run_instr(1'b0, 6'h3f, 0, 0, -1);   // illegal opcode
        run_instr(1'b0, 6'h23, 0, 2, 3);    // reset while waiting in MEMRD
        run_instr(1'b0, 6'h02, 0, 0, -1);   // j
        run_instr(1'b1, 6'h04, 1, 0, -1);   // beq on the plain instance

        for (int k = 0; k < 120; k++) begin
            logic [5:0] op;
            int sel = $urandom_range(0, 10);
            op = (sel == 10) ? 6'($urandom) : op_pool[sel];
            run_instr(1'($urandom), op, $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 15) == 0) ? $urandom_range(0, 6) : -1);
        end

        @(negedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
